// File: rtl/systolic_pkg.sv
// Shared state type, default array sizing and counter-width helper for the
// systolic array control path.
package systolic_pkg;

    localparam int unsigned DEF_N     = 4;
    localparam int unsigned DEF_K_MAX = 256;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        COMPUTE,
        DRAIN,
        DONE
    } ctrl_state_e;

    // Counter must reach k_max + 2n - 2 without wrapping.
    function automatic int unsigned cnt_w(input int unsigned k_max, input int unsigned n);
        return $clog2(k_max + 2 * n);
    endfunction

endpackage

// File: rtl/systolic_skew_gen.sv
// Per-row feed enables and per-anti-diagonal accumulate enables, derived from
// the compute cycle counter t and the latched inner dimension k.
module systolic_skew_gen
    import systolic_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned CNT_W = cnt_w(DEF_K_MAX, DEF_N)
) (
    input  logic             i_active,
    input  logic [CNT_W-1:0] i_t,
    input  logic [CNT_W-1:0] i_k,
    output logic [N-1:0]     o_feed_en,
    output logic [2*N-2:0]   o_acc_en
);

    // One spare bit so that offset + k can never overflow the comparison.
    localparam int unsigned EXT_W = CNT_W + 1;

    logic [EXT_W-1:0] w_t;
    logic [EXT_W-1:0] w_k;

    assign w_t = {1'b0, i_t};
    assign w_k = {1'b0, i_k};

    always_comb begin
        o_feed_en = '0;
        for (int unsigned r = 0; r < N; r++) begin
            o_feed_en[r] = i_active && (w_t >= EXT_W'(r)) && (w_t < EXT_W'(r) + w_k);
        end
    end

    // Diagonal d lags its operands by one register stage inside the PE.
    always_comb begin
        o_acc_en = '0;
        for (int unsigned d = 0; d < 2 * N - 1; d++) begin
            o_acc_en[d] = i_active && (w_t >= EXT_W'(d + 1)) && (w_t < EXT_W'(d + 1) + w_k);
        end
    end

endmodule

// File: rtl/systolic_ctrl.sv
// Job sequencer for an N x N output-stationary systolic array: clear, skewed
// compute window, back-pressured row drain and done handshake.
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned K_MAX = DEF_K_MAX,
    parameter int unsigned CNT_W = cnt_w(K_MAX, N),
    localparam int unsigned ROW_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [CNT_W-1:0] k_len_i,
    input  logic             drain_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             clear_o,
    output logic [N-1:0]     feed_en_o,
    output logic [CNT_W-1:0] feed_idx_o,
    output logic [2*N-2:0]   acc_en_o,
    output logic             drain_valid_o,
    output logic [ROW_W-1:0] drain_row_o
);

    ctrl_state_e      r_state;
    ctrl_state_e      w_next_state;
    logic [CNT_W-1:0] r_k;
    logic [CNT_W-1:0] w_next_k;
    logic [CNT_W-1:0] r_t;
    logic [CNT_W-1:0] w_next_t;
    logic [ROW_W-1:0] r_row;
    logic [ROW_W-1:0] w_next_row;
    logic [CNT_W-1:0] w_t_last;
    logic [CNT_W-1:0] w_k_clamped;

    assign w_t_last    = r_k + CNT_W'(2 * N - 2);
    assign w_k_clamped = (k_len_i > CNT_W'(K_MAX)) ? CNT_W'(K_MAX) : k_len_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_t     <= '0;
            r_row   <= '0;
        end else begin
            r_state <= w_next_state;
            r_k     <= w_next_k;
            r_t     <= w_next_t;
            r_row   <= w_next_row;
        end
    end

    // t and row fall back to zero outside their own phases so the index
    // outputs idle at zero.
    always_comb begin
        w_next_state = r_state;
        w_next_k     = r_k;
        w_next_t     = '0;
        w_next_row   = '0;
        unique case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_next_k     = w_k_clamped;
                    w_next_state = CLEAR;
                end
            end
            CLEAR: begin
                w_next_state = (r_k == '0) ? DRAIN : COMPUTE;
            end
            COMPUTE: begin
                if (r_t == w_t_last) begin
                    w_next_state = DRAIN;
                end else begin
                    w_next_t = r_t + CNT_W'(1);
                end
            end
            DRAIN: begin
                w_next_row = r_row;
                if (drain_ready_i) begin
                    if (r_row == ROW_W'(N - 1)) begin
                        w_next_row   = '0;
                        w_next_state = DONE;
                    end else begin
                        w_next_row = r_row + ROW_W'(1);
                    end
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        busy_o        = (r_state != IDLE);
        done_o        = (r_state == DONE);
        clear_o       = (r_state == CLEAR);
        drain_valid_o = (r_state == DRAIN);
        drain_row_o   = r_row;
        feed_idx_o    = r_t;
    end

    systolic_skew_gen #(
        .N     (N),
        .CNT_W (CNT_W)
    ) u_skew_gen (
        .i_active  (r_state == COMPUTE),
        .i_t       (r_t),
        .i_k       (r_k),
        .o_feed_en (feed_en_o),
        .o_acc_en  (acc_en_o)
    );

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl: latency table, randomized jobs against
// a cycle-timeline model, plus back-pressure, reset-abort and back-to-back cases.
module tb_systolic_ctrl;

    localparam int N     = 4;
    localparam int K_MAX = 256;
    localparam int CNT_W = $clog2(K_MAX + 2 * N);
    localparam int ROW_W = $clog2(N);
    localparam int AW    = 2 * N - 1;
    localparam int VW    = 3 + N + CNT_W + AW + 1 + ROW_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start_i = 1'b0;
    logic [CNT_W-1:0] k_len_i = '0;
    logic             drain_ready_i = 1'b0;
    logic             busy_o;
    logic             done_o;
    logic             clear_o;
    logic [N-1:0]     feed_en_o;
    logic [CNT_W-1:0] feed_idx_o;
    logic [AW-1:0]    acc_en_o;
    logic             drain_valid_o;
    logic [ROW_W-1:0] drain_row_o;
    logic [VW-1:0]    got_vec;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    systolic_ctrl #(
        .N     (N),
        .K_MAX (K_MAX),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .k_len_i       (k_len_i),
        .drain_ready_i (drain_ready_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .clear_o       (clear_o),
        .feed_en_o     (feed_en_o),
        .feed_idx_o    (feed_idx_o),
        .acc_en_o      (acc_en_o),
        .drain_valid_o (drain_valid_o),
        .drain_row_o   (drain_row_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign got_vec = {busy_o, done_o, clear_o, feed_en_o, feed_idx_o, acc_en_o,
                      drain_valid_o, drain_row_o};

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Timeline model: cycle c counts clock edges after the start edge.
    // c=1 clear, c=2.. compute (t=c-2) unless k=0, then N+ drain cycles, then done.
    task automatic run_job(input int k_in, input int mode, input bit keep_start,
                           output int done_c, output int clear_abs);
        int kk, ds, row, stalls, t;
        bit rdy, seen;
        logic [N-1:0]     e_fe;
        logic [AW-1:0]    e_ae;
        logic [CNT_W-1:0] e_idx;
        logic             e_dv;
        logic [ROW_W-1:0] e_row;
        logic [VW-1:0]    e;
        kk = (k_in > K_MAX) ? K_MAX : k_in;
        ds = (kk == 0) ? 2 : kk + 2 * N + 1;
        row = 0;
        stalls = 0;
        done_c = -1;
        clear_abs = -1;
        seen = 1'b0;
        @(negedge clk);
        start_i = 1'b1;
        k_len_i = CNT_W'(k_in);
        drain_ready_i = 1'b1;
        for (int c = 1; c <= 2000; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) clear_abs = cyc;
            e_fe = '0;
            e_ae = '0;
            e_idx = '0;
            e_dv = 1'b0;
            e_row = '0;
            if (c >= 2 && c < ds) begin
                t = c - 2;
                e_idx = CNT_W'(t);
                for (int r = 0; r < N; r++) e_fe[r] = (t >= r) && (t < r + kk);
                for (int d = 0; d < AW; d++) e_ae[d] = (t >= d + 1) && (t < d + 1 + kk);
            end
            if (c >= ds && (done_c < 0 || c < done_c)) begin
                e_dv = 1'b1;
                e_row = ROW_W'(row);
            end
            e = {1'b1, (c == done_c), (c == 1), e_fe, e_idx, e_ae, e_dv, e_row};
            check($sformatf("job k=%0d mode=%0d c=%0d", k_in, mode, c), 64'(got_vec), 64'(e));
            if (c == done_c) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            case (mode)
                0: rdy = 1'b1;
                1: rdy = ($urandom_range(0, 99) >= 40);
                default: rdy = !(row == 2 && stalls < 3);
            endcase
            if (mode == 2 && !rdy) stalls++;
            drain_ready_i = rdy;
            start_i = keep_start ? 1'b1 : 1'($urandom_range(0, 1));
            k_len_i = CNT_W'($urandom_range(0, 511));
            if (c >= ds && done_c < 0 && rdy) begin
                if (row == N - 1) done_c = c + 1;
                else row++;
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout k=%0d: got no done, expected done at cycle %0d", k_in, done_c);
        end
        @(negedge clk);
        start_i = keep_start;
        drain_ready_i = 1'b1;
    endtask

    typedef struct {
        int k_in;
        int mode;
        int exp_done;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int lat, cl, lat2, cl2, kr;
        tbl[0] = '{8, 0, 21};
        tbl[1] = '{0, 0, 6};
        tbl[2] = '{1, 0, 14};
        tbl[3] = '{2, 0, 15};
        tbl[4] = '{3, 0, 16};
        tbl[5] = '{300, 0, 269};
        tbl[6] = '{256, 0, 269};
        tbl[7] = '{8, 2, 24};

        repeat (2) @(posedge clk);
        #1;
        check("reset outputs", 64'(got_vec), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle after reset", 64'(got_vec), 64'(0));

        for (int i = 0; i < 8; i++) begin
            run_job(tbl[i].k_in, tbl[i].mode, 1'b0, lat, cl);
            check($sformatf("latency k=%0d mode=%0d", tbl[i].k_in, tbl[i].mode),
                  64'(lat), 64'(tbl[i].exp_done));
        end

        for (int j = 0; j < 10; j++) begin
            if ($urandom_range(0, 3) == 0) kr = $urandom_range(250, 511);
            else kr = $urandom_range(0, 20);
            run_job(kr, 1, 1'b0, lat, cl);
        end

        // Abort during compute at t=5.
        @(negedge clk);
        start_i = 1'b1;
        k_len_i = CNT_W'(8);
        drain_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("pre-abort feed_idx", 64'(feed_idx_o), 64'(5));
        #2;
        rst = 1'b1;
        #1;
        check("outputs during abort", 64'(got_vec), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle after abort", 64'(got_vec), 64'(0));
        run_job(2, 0, 1'b0, lat, cl);
        check("latency after abort", 64'(lat), 64'(15));

        // Back-to-back with start held high.
        run_job(3, 0, 1'b1, lat, cl);
        run_job(5, 0, 1'b0, lat2, cl2);
        check("back-to-back clear gap", 64'(cl2 - (cl + lat - 1)), 64'(2));
        check("back-to-back latency", 64'(lat2), 64'(18));

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
